sq_carry_pipe: RTL and testbench

- Downstream of the 51-bit squarer; final adder for the 102-bit square and a second 102-bit addend (shifted cross-product term of wider squares).
- Adds the two operands with a carry-ripple pipeline, one 17-bit digit per stage, so no wide carry chain sits on the critical path.
- Valid/ready on both sides; the full 103-bit sum feeds the modular-reduction stage.

---
 rtl/sq_carry_pipe.sv | 129 ++++++++++++
 tb/tb_sq_carry_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_carry_pipe.sv
// sq_carry_pipe: digit-serial carry-ripple adder pipeline for the squarer's final sum.
// Adds two W-bit operands (W = DIGIT_W*NUM_DIGITS), one digit per register stage, so the
// longest carry chain in any stage is DIGIT_W+1 bits. Output is the full W+1 bit sum.
// Optional feature: define SQ_CARRY_PIPE_TAG_EN to carry a TAG_W-bit tag alongside each sum.
// Handshake: one global advance signal; only the final stage can stall the pipe.

module sq_carry_pipe #(
   parameter int unsigned DIGIT_W    = 17,
   parameter int unsigned NUM_DIGITS = 6
`ifdef SQ_CARRY_PIPE_TAG_EN
   ,
   parameter int unsigned TAG_W      = 8
`endif
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DIGIT_W*NUM_DIGITS-1:0]    in_a,
   input  logic [DIGIT_W*NUM_DIGITS-1:0]    in_b,
`ifdef SQ_CARRY_PIPE_TAG_EN
   input  logic [TAG_W-1:0]                 in_tag,
   output logic [TAG_W-1:0]                 out_tag,
`endif
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DIGIT_W*NUM_DIGITS:0]      out_sum
);

   // Global advance: the whole pipe moves together, bubbles included.
   logic adv;

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_stage
      // Operand digits k..N-1 are presented to this stage; digits 0..k of the result leave it.
      localparam int unsigned OpW  = (NUM_DIGITS - k) * DIGIT_W;
      localparam int unsigned ResW = (k + 1) * DIGIT_W;

      logic [OpW-1:0]     op_a;
      logic [OpW-1:0]     op_b;
      logic               c_in;
      logic               v_in;
      logic [DIGIT_W:0]   dsum;
      logic [ResW-1:0]    res_d;
      logic [ResW-1:0]    res_q;
      logic               cy_q;
      logic               vld_q;
`ifdef SQ_CARRY_PIPE_TAG_EN
      logic [TAG_W-1:0]   t_in;
      logic [TAG_W-1:0]   tag_q;
`endif

      if (k == 0) begin : g_head
         // First digit takes its operands straight from the input port, carry-in is zero.
         assign op_a  = in_a;
         assign op_b  = in_b;
         assign c_in  = 1'b0;
         assign v_in  = in_valid;
         assign res_d = dsum[DIGIT_W-1:0];
`ifdef SQ_CARRY_PIPE_TAG_EN
         assign t_in  = in_tag;
`endif
      end else begin : g_body
         // Later digits consume the remaining operands and carry from the previous stage.
         assign op_a  = g_stage[k-1].g_rem.rem_a_q;
         assign op_b  = g_stage[k-1].g_rem.rem_b_q;
         assign c_in  = g_stage[k-1].cy_q;
         assign v_in  = g_stage[k-1].vld_q;
         assign res_d = {dsum[DIGIT_W-1:0], g_stage[k-1].res_q};
`ifdef SQ_CARRY_PIPE_TAG_EN
         assign t_in  = g_stage[k-1].tag_q;
`endif
      end

      // Single-digit add; the only carry chain in this stage is DIGIT_W+1 bits long.
      assign dsum = {1'b0, op_a[DIGIT_W-1:0]} + {1'b0, op_b[DIGIT_W-1:0]}
                  + {{DIGIT_W{1'b0}}, c_in};

      // Stage state: valid bit, accumulated result digits and the outgoing carry.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q <= 1'b0;
            res_q <= '0;
            cy_q  <= 1'b0;
         end else if (adv) begin
            vld_q <= v_in;
            res_q <= res_d;
            cy_q  <= dsum[DIGIT_W];
         end
      end

      if (k < NUM_DIGITS - 1) begin : g_rem
         // Operand digits not yet consumed; this register narrows by one digit per stage.
         logic [OpW-DIGIT_W-1:0] rem_a_q;
         logic [OpW-DIGIT_W-1:0] rem_b_q;

         // Forward the unconsumed operand digits to the next stage.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rem_a_q <= '0;
               rem_b_q <= '0;
            end else if (adv) begin
               rem_a_q <= op_a[OpW-1:DIGIT_W];
               rem_b_q <= op_b[OpW-1:DIGIT_W];
            end
         end
      end

`ifdef SQ_CARRY_PIPE_TAG_EN
      // Tag travels in lockstep with the digit data of this stage.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            tag_q <= '0;
         end else if (adv) begin
            tag_q <= t_in;
         end
      end
`endif
   end

   // Only the last stage gates the pipe; bubbles are shifted, never squeezed out.
   assign out_valid = g_stage[NUM_DIGITS-1].vld_q;
   assign out_sum   = {g_stage[NUM_DIGITS-1].cy_q, g_stage[NUM_DIGITS-1].res_q};
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
`ifdef SQ_CARRY_PIPE_TAG_EN
   assign out_tag   = g_stage[NUM_DIGITS-1].tag_q;
`endif

endmodule

// File: tb/tb_sq_carry_pipe.sv
// Self-checking bench for sq_carry_pipe: randomized stimulus against a queue model of A+B.
// Tag checks are compiled only when SQ_CARRY_PIPE_TAG_EN is defined.

module tb_sq_carry_pipe;

   localparam int unsigned DIGIT_W    = 17;
   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned W          = DIGIT_W * NUM_DIGITS;
   localparam int          LAT        = NUM_DIGITS - 1;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [W:0]     out_sum;
`ifdef SQ_CARRY_PIPE_TAG_EN
   logic [7:0]     in_tag;
   logic [7:0]     out_tag;
`endif

   int total;
   int bad;

   sq_carry_pipe #(
      .DIGIT_W    (DIGIT_W),
      .NUM_DIGITS (NUM_DIGITS)
`ifdef SQ_CARRY_PIPE_TAG_EN
      ,
      .TAG_W      (8)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef SQ_CARRY_PIPE_TAG_EN
      .in_tag    (in_tag),
      .out_tag   (out_tag),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random operand, biased toward all-ones and zero so long carry ripples get exercised.
   function automatic logic [W-1:0] rand_op();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0: r = '1;
         1: r = '0;
         default: ;
      endcase
      return r[W-1:0];
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
`ifdef SQ_CARRY_PIPE_TAG_EN
      in_tag = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
      end
      total++;
      if (out_sum !== '0) begin
         bad++; $display("FAIL reset_out_sum got=%0h want=0", out_sum);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
      end
`ifdef SQ_CARRY_PIPE_TAG_EN
      total++;
      if (out_tag !== '0) begin
         bad++; $display("FAIL reset_out_tag got=%0h want=0", out_tag);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_latency();
      logic [W:0] want;
      int lat;
      want = '0;
      want[W] = 1'b1;
      @(posedge clk); #1;
      in_a = 1; in_b = '1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int e = 0; e < 20 && lat < 0; e++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = e;
            total++;
            if (out_sum !== want) begin
               bad++; $display("FAIL latency_sum got=%0h want=%0h", out_sum, want);
            end
         end else begin
            @(posedge clk); #1;
         end
      end
      total++;
      if (lat != LAT) begin
         bad++; $display("FAIL latency_cycles got=%0d want=%0d", lat, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_max_b2b();
      logic [W:0] want;
      bit found;
      want = {1'b0, {W{1'b1}}} + {1'b0, {W{1'b1}}};
      @(posedge clk); #1;
      in_a = '1; in_b = '1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_a = '0; in_b = '0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (out_valid) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      total++;
      if (!found || out_sum !== want) begin
         bad++; $display("FAIL max_sum got=%0h want=%0h seen=%0b", out_sum, want, found);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_sum !== '0) begin
         bad++; $display("FAIL zero_b2b got_valid=%0b got=%0h want=0", out_valid, out_sum);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      logic [W:0] exp_q[$];
      logic [W:0] want;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int got;
      int gaps;
      bit started;
      got = 0; gaps = 0; started = 1'b0;
      for (int c = 0; c < 140; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (c < 100) begin
            a = rand_op(); b = rand_op();
            in_a = a; in_b = b; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
         if (out_valid) begin
            started = 1'b1;
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL stream_extra got=%0h want=none", out_sum);
            end else begin
               want = exp_q.pop_front();
               if (out_sum !== want) begin
                  bad++; $display("FAIL stream_sum got=%0h want=%0h", out_sum, want);
               end
            end
            got++;
         end else if (started && got < 100) begin
            gaps++;
         end
      end
      total++;
      if (got != 100 || gaps != 0) begin
         bad++; $display("FAIL stream_count got=%0d gaps=%0d want=100 gaps=0", got, gaps);
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] exp_q[$];
      logic [W:0] want;
      logic [W:0] held;
      bit stall_prev;
      stall_prev = 1'b0; held = '0;
      for (int c = 0; c < 340; c++) begin
         @(posedge clk); #1;
         if (c < 300) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = rand_op(); in_b = rand_op();
            out_ready = $urandom_range(0, 1);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         @(negedge clk);
         total++;
         if (in_ready !== (!out_valid || out_ready)) begin
            bad++; $display("FAIL bp_in_ready got=%0b want=%0b", in_ready, !out_valid || out_ready);
         end
         if (stall_prev) begin
            total++;
            if (out_valid !== 1'b1 || out_sum !== held) begin
               bad++; $display("FAIL bp_stall_hold got=%0h want=%0h", out_sum, held);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL bp_extra got=%0h want=none", out_sum);
            end else begin
               want = exp_q.pop_front();
               if (out_sum !== want) begin
                  bad++; $display("FAIL bp_sum got=%0h want=%0h", out_sum, want);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
         stall_prev = out_valid && !out_ready;
         held = out_sum;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL bp_lost got=%0d left want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      bit full;
      int lat;
      int outs;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_a = rand_op(); in_b = rand_op(); in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      full = 1'b0;
      for (int i = 0; i < 20 && !full; i++) begin
         @(negedge clk);
         if (out_valid) full = 1'b1;
      end
      total++;
      if (!full) begin
         bad++; $display("FAIL mid_fill got_valid=0 want=1");
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset got_valid=%0b got_sum=%0h got_ready=%0b want=0,0,1",
                  out_valid, out_sum, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      in_a = 5; in_b = 7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; outs = 0;
      for (int e = 0; e < 20; e++) begin
         @(negedge clk);
         if (out_valid) begin
            outs++;
            if (lat < 0) begin
               lat = e;
               total++;
               if (out_sum !== 103'd12) begin
                  bad++; $display("FAIL mid_new_sum got=%0h want=c", out_sum);
               end
            end
         end
         @(posedge clk); #1;
      end
      total++;
      if (lat != LAT || outs != 1) begin
         bad++; $display("FAIL mid_new_timing got_lat=%0d outs=%0d want_lat=%0d outs=1",
                         lat, outs, LAT);
      end
   endtask

`ifdef SQ_CARRY_PIPE_TAG_EN
   task automatic test_tags();
      logic [W:0] exp_q[$];
      logic [7:0] tag_q[$];
      logic [W:0] want;
      logic [7:0] want_tag;
      logic [7:0] held_tag;
      bit stall_prev;
      int idx;
      int got;
      idx = 0; got = 0; stall_prev = 1'b0; held_tag = '0;
      for (int c = 0; c < 400 && got < 16; c++) begin
         @(posedge clk); #1;
         in_valid = (idx < 16) && ($urandom_range(0, 2) != 0);
         in_tag = 8'(idx + 1);
         in_a = rand_op(); in_b = rand_op();
         out_ready = $urandom_range(0, 1);
         @(negedge clk);
         if (stall_prev) begin
            total++;
            if (out_tag !== held_tag) begin
               bad++; $display("FAIL tag_hold got=%0h want=%0h", out_tag, held_tag);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL tag_extra got=%0h want=none", out_tag);
            end else begin
               want = exp_q.pop_front();
               want_tag = tag_q.pop_front();
               if (out_tag !== want_tag || out_sum !== want) begin
                  bad++;
                  $display("FAIL tag_pair got=%0h/%0h want=%0h/%0h",
                           out_tag, out_sum, want_tag, want);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
            tag_q.push_back(in_tag);
            idx++;
         end
         stall_prev = out_valid && !out_ready;
         held_tag = out_tag;
      end
      total++;
      if (got != 16) begin
         bad++; $display("FAIL tag_count got=%0d want=16", got);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
`ifdef SQ_CARRY_PIPE_TAG_EN
      in_tag = '0;
`endif
      test_reset();
      test_latency();
      test_max_b2b();
      test_stream();
      test_backpressure();
      test_reset_midflight();
`ifdef SQ_CARRY_PIPE_TAG_EN
      test_tags();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
